// File: rtl/pc_unit.sv
// Program counter unit: sequential fetch, branch/jump/register-jump redirects,
// exception entry/return, and a one-deep deferred redirect held across stalls.
module pc_unit #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   RESET_VEC = 'h0000_3000,
    parameter logic [ADDR_W-1:0]   EXC_VEC   = 'h0000_4180
) (
    input  logic              clock,
    input  logic              flag_reset,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              br_take,
    input  logic [15:0]       br_off,
    input  logic              jmp,
    input  logic [25:0]       jmp_idx,
    input  logic              jr,
    input  logic [ADDR_W-3:0] jr_addr,
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-3:0] pc,
    output logic [ADDR_W-3:0] pc_plus4,
    output logic [ADDR_W-3:0] epc,
    output logic              redir_pend
);

    localparam int unsigned PW = ADDR_W - 2;

    typedef enum logic {RUN, PEND} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pend_tgt, pend_tgt_n;
    logic [PW-1:0] pc_n, epc_n;
    logic [PW-1:0] br_tgt, jmp_tgt, req_tgt;
    logic          advance, req;

    assign pc_plus4   = pc + 1'b1;
    assign advance    = imem_ready & ~stall;
    assign req        = jr | jmp | br_take;
    assign redir_pend = (state == PEND);
    assign br_tgt     = pc_plus4 + {{(PW-16){br_off[15]}}, br_off};

    // Jump keeps the upper region bits of pc_plus4; works down to a 26-bit word address.
    always_comb begin
        jmp_tgt       = pc_plus4;
        jmp_tgt[25:0] = jmp_idx;
    end

    always_comb begin
        req_tgt = br_tgt;
        if (jr)
            req_tgt = jr_addr;
        else if (jmp)
            req_tgt = jmp_tgt;
    end

    always_comb begin
        pc_n       = pc;
        epc_n      = epc;
        pend_tgt_n = pend_tgt;
        state_n    = state;
        if (exc) begin
            pc_n    = EXC_VEC[ADDR_W-1:2];
            epc_n   = pc;
            state_n = RUN;
        end else if (eret) begin
            pc_n    = epc;
            state_n = RUN;
        end else if (req) begin
            if (advance) begin
                pc_n    = req_tgt;
                state_n = RUN;
            end else begin
                pend_tgt_n = req_tgt;
                state_n    = PEND;
            end
        end else if (state == PEND) begin
            if (advance) begin
                pc_n    = pend_tgt;
                state_n = RUN;
            end
        end else if (advance) begin
            pc_n = pc_plus4;
        end
    end

    always_ff @(posedge clock) begin
        if (flag_reset) begin
            pc       <= RESET_VEC[ADDR_W-1:2];
            epc      <= '0;
            pend_tgt <= '0;
            state    <= RUN;
        end else begin
            pc       <= pc_n;
            epc      <= epc_n;
            pend_tgt <= pend_tgt_n;
            state    <= state_n;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: hand-computed word addresses checked after each edge.
module tb_pc_unit;

    logic        clock;
    logic        flag_reset, imem_ready, stall;
    logic        br_take, jmp, jr, exc, eret;
    logic [15:0] br_off;
    logic [25:0] jmp_idx;
    logic [29:0] jr_addr;
    logic [29:0] pc, pc_plus4, epc;
    logic        redir_pend;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0000_3000), .EXC_VEC(32'h0000_4180)) dut (
        .clock(clock), .flag_reset(flag_reset), .imem_ready(imem_ready), .stall(stall),
        .br_take(br_take), .br_off(br_off), .jmp(jmp), .jmp_idx(jmp_idx),
        .jr(jr), .jr_addr(jr_addr), .exc(exc), .eret(eret),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .redir_pend(redir_pend)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic clr();
        br_take = 1'b0; jmp = 1'b0; jr = 1'b0; exc = 1'b0; eret = 1'b0;
    endtask

    initial begin
        flag_reset = 1'b1; imem_ready = 1'b0; stall = 1'b0;
        br_off = '0; jmp_idx = '0; jr_addr = '0;
        clr();
        tick();
        chk("rst_pc", {2'b0, pc}, 32'hC00);
        chk("rst_epc", {2'b0, epc}, 32'h0);
        chk("rst_pend", {31'b0, redir_pend}, 32'h0);
        chk("rst_pc4", {2'b0, pc_plus4}, 32'hC01);

        flag_reset = 1'b0; imem_ready = 1'b1;
        tick(); chk("seq1", {2'b0, pc}, 32'hC01);
        tick(); chk("seq2", {2'b0, pc}, 32'hC02);
        tick(); chk("seq3", {2'b0, pc}, 32'hC03);
        tick(); chk("seq4", {2'b0, pc}, 32'hC04);

        br_take = 1'b1; br_off = 16'hFFFC;
        tick(); chk("br_back", {2'b0, pc}, 32'hC01);
        br_take = 1'b0; imem_ready = 1'b0;
        tick(); chk("hold_nordy", {2'b0, pc}, 32'hC01);

        flag_reset = 1'b1;
        tick(); chk("rst2_pc", {2'b0, pc}, 32'hC00);
        flag_reset = 1'b0; imem_ready = 1'b1; br_take = 1'b1; br_off = 16'h0010;
        tick(); chk("br_fwd", {2'b0, pc}, 32'hC11);

        br_off = 16'h002E; stall = 1'b1;
        tick(); chk("pend_pc", {2'b0, pc}, 32'hC11);
        chk("pend_flag", {31'b0, redir_pend}, 32'h1);
        br_take = 1'b0;
        tick(); chk("pend_hold", {2'b0, pc}, 32'hC11);
        chk("pend_hold_flag", {31'b0, redir_pend}, 32'h1);
        stall = 1'b0;
        tick(); chk("pend_go", {2'b0, pc}, 32'hC40);
        chk("pend_go_flag", {31'b0, redir_pend}, 32'h0);

        jr = 1'b1; jr_addr = 30'hC08;
        tick(); chk("jr", {2'b0, pc}, 32'hC08);
        jr = 1'b0;

        exc = 1'b1; stall = 1'b1;
        tick(); chk("exc_pc", {2'b0, pc}, 32'h1060);
        chk("exc_epc", {2'b0, epc}, 32'hC08);
        exc = 1'b0; stall = 1'b0;
        tick(); chk("exc_seq", {2'b0, pc}, 32'h1061);
        eret = 1'b1; stall = 1'b1; imem_ready = 1'b0;
        tick(); chk("eret_pc", {2'b0, pc}, 32'hC08);
        chk("eret_epc", {2'b0, epc}, 32'hC08);
        eret = 1'b0; stall = 1'b0; imem_ready = 1'b1;

        jr = 1'b1; jr_addr = 30'h1400; jmp = 1'b1; jmp_idx = 26'h0123456;
        br_take = 1'b1; br_off = 16'h0010;
        tick(); chk("prio_jr", {2'b0, pc}, 32'h1400);
        jr = 1'b0;
        tick(); chk("prio_jmp", {2'b0, pc}, 32'h0123456);
        jmp = 1'b0;
        tick(); chk("br_after_jmp", {2'b0, pc}, 32'h0123467);
        br_take = 1'b0;

        exc = 1'b1; eret = 1'b1;
        tick(); chk("exc_eret_pc", {2'b0, pc}, 32'h1060);
        chk("exc_eret_epc", {2'b0, epc}, 32'h0123467);
        clr();

        jr = 1'b1; jr_addr = 30'h3FFF_FFFF;
        tick(); chk("jr_max", {2'b0, pc}, 32'h3FFF_FFFF);
        chk("pc4_wrap", {2'b0, pc_plus4}, 32'h0);
        jr = 1'b0;
        tick(); chk("seq_wrap", {2'b0, pc}, 32'h0);
        br_take = 1'b1; br_off = 16'hFFFE;
        tick(); chk("br_wrap", {2'b0, pc}, 32'h3FFF_FFFF);
        br_take = 1'b0;

        jr = 1'b1; jr_addr = 30'h2C00_0000;
        tick(); chk("jr_hi", {2'b0, pc}, 32'h2C00_0000);
        jr = 1'b0; jmp = 1'b1; jmp_idx = 26'h0000015;
        tick(); chk("jmp_region", {2'b0, pc}, 32'h2C00_0015);
        jmp = 1'b0;

        stall = 1'b1; br_take = 1'b1; br_off = 16'h0001;
        tick(); chk("ovw_pend", {31'b0, redir_pend}, 32'h1);
        br_take = 1'b0; jmp = 1'b1; jmp_idx = 26'h0000100;
        tick(); chk("ovw_hold", {2'b0, pc}, 32'h2C00_0015);
        jmp = 1'b0; stall = 1'b0;
        tick(); chk("ovw_go", {2'b0, pc}, 32'h2C00_0100);

        stall = 1'b1; jr = 1'b1; jr_addr = 30'h111;
        tick(); chk("pend_new_flag", {31'b0, redir_pend}, 32'h1);
        jr_addr = 30'h222; stall = 1'b0;
        tick(); chk("pend_new_go", {2'b0, pc}, 32'h222);
        chk("pend_new_flag0", {31'b0, redir_pend}, 32'h0);
        jr = 1'b0;

        stall = 1'b1; br_take = 1'b1; br_off = 16'h0040;
        tick(); chk("pexc_pend", {31'b0, redir_pend}, 32'h1);
        br_take = 1'b0; exc = 1'b1;
        tick(); chk("pexc_pc", {2'b0, pc}, 32'h1060);
        chk("pexc_epc", {2'b0, epc}, 32'h222);
        chk("pexc_flag", {31'b0, redir_pend}, 32'h0);
        exc = 1'b0; stall = 1'b0;
        tick(); chk("pexc_discard", {2'b0, pc}, 32'h1061);

        stall = 1'b1; jr = 1'b1; jr_addr = 30'h500;
        tick(); chk("rpend_flag", {31'b0, redir_pend}, 32'h1);
        jr = 1'b0; exc = 1'b1; flag_reset = 1'b1;
        tick(); chk("rpend_pc", {2'b0, pc}, 32'hC00);
        chk("rpend_epc", {2'b0, epc}, 32'h0);
        chk("rpend_flag0", {31'b0, redir_pend}, 32'h0);
        exc = 1'b0; flag_reset = 1'b0; stall = 1'b0;
        tick(); chk("post_rst_seq", {2'b0, pc}, 32'hC01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
